// File: rtl/bin2qdi_token_sched.sv
// bin2qdi_token_sched: round-robin token scheduler driving Bin2QDI_1of1 req/Re handshakes with timeout
// Ports: CLK/RESET (async, active-high); tok_valid/tok_ch/tok_ready push tokens into per-channel
// pending counters; req/Re are the 4-phase handshake per channel (Re asynchronous, synchronized here);
// clr_err clears a timeout; busy, timeout_err, err_ch and done_cnt report status.
module bin2qdi_token_sched #(
  parameter int NCH = 4,
  parameter int CW  = 4,
  parameter int TMO = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    tok_valid,
  input  logic [$clog2(NCH)-1:0]  tok_ch,
  output logic                    tok_ready,
  output logic [NCH-1:0]          req,
  input  logic [NCH-1:0]          Re,
  input  logic                    clr_err,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [$clog2(NCH)-1:0]  err_ch,
  output logic [15:0]             done_cnt
);
  localparam int CHW = $clog2(NCH);
  typedef enum logic [1:0] {IDLE, REQ, REL, ERR} state_t;
  state_t st_q, st_d;
  logic [NCH-1:0] s1_q, sre_q, req_q, req_d, nz;
  logic [NCH-1:0][CW-1:0] pend_q, pend_d;
  logic [CHW-1:0] g_q, g_d, last_q, last_d, err_ch_q, err_ch_d, pick;
  logic [15:0] done_q, done_d, cnt_q, cnt_d;
  logic err_q, err_d, push, fin, tmo_hit;
  always_comb
    for (int i = 0; i < NCH; i++) nz[i] = pend_q[i] != '0;
  // Scan downward so the last hit is the nearest channel after last_q, wrapping onto last_q itself.
  always_comb begin
    pick = '0;
    for (int i = NCH; i >= 1; i--)
      if (nz[(int'(last_q) + i) % NCH]) pick = CHW'((int'(last_q) + i) % NCH);
  end
  assign tok_ready = st_q != ERR && int'(tok_ch) < NCH && pend_q[tok_ch] != {CW{1'b1}};
  assign push = tok_valid && tok_ready;
  assign tmo_hit = cnt_q == 16'(TMO - 1);
  always_comb begin
    st_d = st_q;
    g_d = g_q;
    last_d = last_q;
    err_d = err_q;
    err_ch_d = err_ch_q;
    done_d = done_q;
    cnt_d = cnt_q + 16'd1;
    fin = 1'b0;
    case (st_q)
      IDLE: if (|nz) begin
        st_d = REQ;
        g_d = pick;
        cnt_d = '0;
      end
      REQ: if (!sre_q[g_q]) begin
        st_d = REL;
        cnt_d = '0;
      end else if (tmo_hit) begin
        st_d = ERR;
        err_d = 1'b1;
        err_ch_d = g_q;
      end
      REL: if (sre_q[g_q]) begin
        st_d = IDLE;
        fin = 1'b1;
        done_d = done_q + 16'd1;
        last_d = g_q;
      end else if (tmo_hit) begin
        st_d = ERR;
        err_d = 1'b1;
        err_ch_d = g_q;
      end
      default: if (clr_err) begin
        st_d = IDLE;
        err_d = 1'b0;
      end
    endcase
    // A push and a completion on the same channel cancel out.
    for (int i = 0; i < NCH; i++)
      pend_d[i] = pend_q[i] + CW'(push && tok_ch == CHW'(i)) - CW'(fin && g_q == CHW'(i));
    req_d = st_d == REQ ? {{(NCH-1){1'b0}}, 1'b1} << g_d : '0;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      s1_q <= '1;
      sre_q <= '1;
      st_q <= IDLE;
      g_q <= '0;
      last_q <= CHW'(NCH - 1);
      err_q <= 1'b0;
      err_ch_q <= '0;
      done_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      req_q <= '0;
    end else begin
      s1_q <= Re;
      sre_q <= s1_q;
      st_q <= st_d;
      g_q <= g_d;
      last_q <= last_d;
      err_q <= err_d;
      err_ch_q <= err_ch_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      req_q <= req_d;
    end
  assign req = req_q;
  assign busy = st_q == REQ || st_q == REL || |nz;
  assign timeout_err = err_q;
  assign err_ch = err_ch_q;
  assign done_cnt = done_q;
endmodule

// File: tb/tb_bin2qdi_token_sched.sv
// tb_bin2qdi_token_sched: directed and randomized checks of the token scheduler against a transaction-level model
module tb_bin2qdi_token_sched;
  localparam int TMO = 40;
  logic CLK = 0, RESET = 1, tok_valid = 0, clr_err = 0;
  logic [1:0] tok_ch = '0, err_ch;
  logic [3:0] Re, req;
  logic tok_ready, busy, timeout_err;
  logic [15:0] done_cnt;
  int tests = 0, fails = 0;

  bin2qdi_token_sched #(.NCH(4), .CW(4), .TMO(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .tok_valid(tok_valid), .tok_ch(tok_ch), .tok_ready(tok_ready),
    .req(req), .Re(Re), .clr_err(clr_err), .busy(busy), .timeout_err(timeout_err),
    .err_ch(err_ch), .done_cnt(done_cnt));

  always #5 CLK = ~CLK;

  // QDI environment: auto channels answer req with random delay, others hold force_v.
  logic [3:0] re_a = '1, auto_m = '0, force_v = '1;
  int wt[4] = '{default: 0};
  int dl[4] = '{default: 0};
  assign Re = (auto_m & re_a) | (~auto_m & force_v);
  always @(negedge CLK)
    for (int c = 0; c < 4; c++) begin
      if (!auto_m[c]) begin
        re_a[c] = 1'b1;
        wt[c] = 0;
      end else if (re_a[c] == req[c]) begin
        if (wt[c] >= dl[c]) begin
          re_a[c] = ~req[c];
          wt[c] = 0;
          dl[c] = $urandom_range(0, 4);
        end else wt[c]++;
      end
    end

  // Transaction model: ungranted token counts and the last granted channel.
  int mp[4] = '{default: 0};
  int ml = 3, pp_c = 0, mg, me;
  bit pp_v = 0, chk_on = 0;
  logic [3:0] prev_req = '0;
  int gq[$];

  function automatic int rr(input int last);
    for (int i = 1; i <= 4; i++)
      if (mp[(last + i) % 4] > 0) return (last + i) % 4;
    return -1;
  endfunction

  function automatic int ch_of(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  always @(posedge CLK)
    if (RESET) begin
      mp = '{default: 0};
      ml = 3;
      pp_v = 0;
      prev_req = '0;
      gq.delete();
    end else begin
      if (chk_on) begin
        tests++;
        assert ($onehot0(req)) else begin
          fails++;
          $error("FAIL onehot_req: req=%b required at most one bit", req);
        end
        if (tok_valid) begin
          tests++;
          assert (tok_ready === 1'b1) else begin
            fails++;
            $error("FAIL rand_ready: got %b expected 1", tok_ready);
          end
        end
      end
      if (req != '0 && prev_req == '0) begin
        mg = ch_of(req);
        me = rr(ml);
        gq.push_back(mg);
        if (chk_on) begin
          tests++;
          assert (mg === me) else begin
            fails++;
            $error("FAIL rr_grant: got ch %0d expected ch %0d", mg, me);
          end
        end
        if (me >= 0) mp[me]--;
        ml = mg;
      end
      if (pp_v) mp[pp_c]++;
      pp_v = tok_valid;
      pp_c = int'(tok_ch);
      prev_req = req;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int mx);
    int n = 0;
    while (busy !== 1'b0 && n < mx) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_busy", 32'(busy), 0);
  endtask

  task automatic push1(input int c);
    tok_ch = 2'(c);
    tok_valid = 1;
    @(negedge CLK);
    tok_valid = 0;
  endtask

  initial begin
    int base, total, cnt[4];
    int exp_ord[6] = '{0, 1, 3, 0, 1, 3};
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_errch", 32'(err_ch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(tok_ready), 1);
    repeat (2) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);

    // Single token on ch 2 with a hand-driven Re
    push1(2);
    chk("t1_req_k", 32'(req), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge CLK);
    chk("t1_req_k1", 32'(req), 4);
    repeat (3) @(negedge CLK);
    chk("t1_req_hold", 32'(req), 4);
    force_v[2] = 0;
    repeat (2) @(negedge CLK);
    chk("t1_req_sync", 32'(req), 4);
    @(negedge CLK);
    chk("t1_req_fall", 32'(req), 0);
    force_v[2] = 1;
    repeat (2) @(negedge CLK);
    chk("t1_done_early", 32'(done_cnt), 0);
    @(negedge CLK);
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_busy_end", 32'(busy), 0);

    // Two tokens each on ch 0,1,3: round-robin order
    base = int'(done_cnt);
    auto_m = '1;
    gq.delete();
    for (int i = 0; i < 6; i++) push1(exp_ord[i]);
    wait_idle(2000);
    chk("t2_ngrant", 32'(gq.size()), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("t2_order", 32'(gq[i]), 32'(exp_ord[i]));
    chk("t2_done", 32'(done_cnt), 32'(base + 6));

    // Saturate ch 1 with Re held high
    base = int'(done_cnt);
    auto_m = '0;
    force_v = '1;
    tok_ch = 1;
    tok_valid = 1;
    for (int i = 0; i < 15; i++) begin
      #1 chk("t3_ready_fill", 32'(tok_ready), 1);
      @(negedge CLK);
    end
    #1 chk("t3_ready_full", 32'(tok_ready), 0);
    @(negedge CLK);
    tok_valid = 0;
    tok_ch = 0;
    #1 chk("t3_ready_other", 32'(tok_ready), 1);
    auto_m = '1;
    wait_idle(3000);
    chk("t3_done15", 32'(done_cnt), 32'(base + 15));
    chk("t3_no_tmo", 32'(timeout_err), 0);

    // Re[0] never falls: timeout, ERR behaviour, clear and re-grant
    base = int'(done_cnt);
    auto_m = '0;
    force_v = '1;
    push1(0);
    @(negedge CLK);
    chk("t4_req", 32'(req), 1);
    repeat (TMO - 1) @(negedge CLK);
    chk("t4_tmo_early", 32'(timeout_err), 0);
    chk("t4_req_early", 32'(req), 1);
    @(negedge CLK);
    chk("t4_tmo", 32'(timeout_err), 1);
    chk("t4_errch", 32'(err_ch), 0);
    chk("t4_req_off", 32'(req), 0);
    chk("t4_busy", 32'(busy), 1);
    tok_ch = 0;
    tok_valid = 1;
    #1 chk("t4_ready_err", 32'(tok_ready), 0);
    @(negedge CLK);
    tok_valid = 0;
    repeat (2) @(negedge CLK);
    chk("t4_req_err", 32'(req), 0);
    chk("t4_done_held", 32'(done_cnt), 32'(base));
    chk("t4_tmo_sticky", 32'(timeout_err), 1);
    clr_err = 1;
    @(negedge CLK);
    clr_err = 0;
    chk("t4_tmo_clr", 32'(timeout_err), 0);
    @(negedge CLK);
    chk("t4_regrant", 32'(req), 1);
    auto_m = '1;
    wait_idle(2000);
    chk("t4_done1", 32'(done_cnt), 32'(base + 1));

    // Reset while in REL on ch 2
    auto_m = '0;
    force_v = '1;
    push1(2);
    push1(1);
    push1(3);
    force_v[2] = 0;
    repeat (3) @(negedge CLK);
    chk("t5_rel_req", 32'(req), 0);
    chk("t5_rel_busy", 32'(busy), 1);
    #2 RESET = 1;
    tok_valid = 1;
    tok_ch = 1;
    #1;
    chk("t5_req", 32'(req), 0);
    chk("t5_done", 32'(done_cnt), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_tmo", 32'(timeout_err), 0);
    repeat (2) @(negedge CLK);
    RESET = 0;
    tok_valid = 0;
    force_v[2] = 1;
    #1 chk("t5_ready", 32'(tok_ready), 1);
    @(negedge CLK);
    chk("t5_busy_after", 32'(busy), 0);
    repeat (4) @(negedge CLK);
    chk("t5_req_after", 32'(req), 0);
    chk("t5_done_after", 32'(done_cnt), 0);

    // Randomized pushes against the round-robin model
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    auto_m = '1;
    chk_on = 1;
    total = 0;
    cnt = '{default: 0};
    for (int i = 0; i < 80; i++) begin
      int v, c;
      v = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 3));
      if (cnt[c] >= 8) v = 0;
      tok_ch = 2'(c);
      tok_valid = v[0];
      if (v != 0) begin
        cnt[c]++;
        total++;
      end
      @(negedge CLK);
    end
    tok_valid = 0;
    wait_idle(4000);
    chk("t6_done", 32'(done_cnt), 32'(total));
    chk("t6_ngrant", 32'(gq.size()), 32'(total));
    chk("t6_tmo", 32'(timeout_err), 0);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bin2qdi_token_sched.md
BIN2QDI_TOKEN_SCHED -- requirements
Module: bin2qdi_token_sched

Interface
REQ-001 Parameter NCH, default 4, number of e1of1 driver channels sequenced (2..8).
REQ-002 Parameter CW, default 4, width of each per-channel pending-token counter.
REQ-003 Parameter TMO, default 255, handshake phase timeout in CLK cycles (1..2^16-1).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 tok_valid  input  1  token push request from the verilog test environment.
REQ-007 tok_ch  input  clog2(NCH)  target channel index of the pushed token.
REQ-008 tok_ready  output  1  high when a push to tok_ch can be accepted this cycle.
REQ-009 req  output  NCH  per-channel request to the Bin2QDI_1of1 driver req input.
REQ-010 Re  input  NCH  per-channel right enable returned from the QDI circuit; asynchronous to CLK.
REQ-011 clr_err  input  1  synchronous clear of the error state.
REQ-012 busy  output  1  high when any channel has pending tokens or a handshake is in progress.
REQ-013 timeout_err  output  1  sticky handshake-timeout flag.
REQ-014 err_ch  output  clog2(NCH)  channel index that timed out.
REQ-015 done_cnt  output  16  count of completed handshakes, wraps modulo 2^16.

Function
REQ-016 Each Re bit SHALL pass through a 2-flop synchronizer; only synchronized Re (sRe) SHALL be used.
REQ-017 Push SHALL occur on a CLK edge with tok_valid && tok_ready; pending[tok_ch] increments by 1.
REQ-018 tok_ready SHALL be low when pending[tok_ch] == 2^CW-1 or the FSM is in ERR; otherwise high.
REQ-019 FSM states: IDLE, REQ, REL, ERR; at most one req bit SHALL be high at any time.
REQ-020 IDLE: if any pending > 0, grant channel g = first channel with pending > 0 searching round-robin from last_grant+1; go to REQ.
REQ-021 REQ: req[g] = 1; on sRe[g] == 0 go to REL.
REQ-022 REL: req[g] = 0; on sRe[g] == 1, decrement pending[g], increment done_cnt, set last_grant = g, go to IDLE.
REQ-023 req SHALL be a registered output decoded from state and g; req[g] rises on the first edge after the IDLE grant edge.
REQ-024 A push accepted at edge k to an idle block SHALL cause req high after edge k+1.
REQ-025 Simultaneous push and completion on the same channel SHALL leave pending unchanged.
REQ-026 A phase cycle counter SHALL clear on entry to REQ and REL and increment each cycle in them.
REQ-027 When the counter reaches TMO without the awaited sRe level, SHALL go to ERR, set timeout_err = 1, err_ch = g, req = 0.
REQ-028 ERR: no grants, no pushes; pending and done_cnt held; clr_err clears timeout_err and returns to IDLE.
REQ-029 busy = (state != IDLE && state != ERR) || any pending > 0.
REQ-030 last_grant SHALL initialize to NCH-1 so channel 0 has first priority after reset.

Reset
REQ-031 RESET high SHALL immediately force req = 0, state = IDLE, all pending = 0, done_cnt = 0, timeout_err = 0, err_ch = 0, last_grant = NCH-1, synchronizer flops = 1.
REQ-032 RESET asserted mid-handshake SHALL abandon the handshake with no done_cnt increment; tok_valid is ignored while RESET is high.

Verification
REQ-033 Single token ch 2, Re follows req after 3 cycles -> req[2] high after edge k+1, falls after sRe 0, done_cnt = 1, busy low.
REQ-034 Two tokens each on ch 0,1,3 pushed together -> grant order 0,1,3,0,1,3; done_cnt = 6.
REQ-035 Push 15 tokens to ch 1 with Re held high (CW = 4) -> tok_ready low at pending = 15, 16th push rejected.
REQ-036 Re[0] never falls -> after TMO cycles in REQ timeout_err = 1, err_ch = 0, req = 0; clr_err -> IDLE, re-grant ch 0.
REQ-037 RESET pulse while in REL on ch 2 -> req = 0 immediately, pending all 0, done_cnt = 0, tok_ready = 1 after release.
